cprv_mem_stage: RTL and testbench

- Pipeline stage directly downstream of the execute stage.
- Consumes the registered EX→MEM bundle (ALU result, rs2 data, rd, opcode/funct3) and performs RV64 loads/stores on a data-memory req/ack port.
- Load data is aligned and sign/zero-extended; non-memory results pass through.
- Single result register feeds writeback over a valid/ready handshake.

---
 rtl/cprv_pkg.sv | 21 ++
 rtl/cprv_lsu_align.sv | 43 ++++
 rtl/cprv_mem_stage.sv | 133 +++++++++++++
 tb/tb_cprv_mem_stage.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cprv_pkg.sv
// cprv_pkg: shared opcodes, funct3 access-size codes and MEM-stage FSM states
package cprv_pkg;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        HOLD
    } mem_state_t;

endpackage

// File: rtl/cprv_lsu_align.sv
// cprv_lsu_align: byte-lane placement for stores, extract/extend for loads, misalign detection
module cprv_lsu_align
    import cprv_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic [1:0]            size,
    input  logic [2:0]            off,
    input  logic [DATA_WIDTH-1:0] st_data,
    output logic [7:0]            wstrb,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic                  misalign,
    input  logic [2:0]            ld_funct3,
    input  logic [2:0]            ld_off,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic [DATA_WIDTH-1:0] ld_data
);

    logic [DATA_WIDTH-1:0] sh;

    // Store side: shift data and strobes into the addressed lanes; flag accesses that cross their natural size
    always_comb begin
        wdata    = st_data << {off, 3'b000};
        wstrb    = (size == F3_D[1:0]) ? 8'hFF :
                   (size == F3_W[1:0]) ? (8'h0F << off) :
                   (size == F3_H[1:0]) ? (8'h03 << off) : (8'h01 << off);
        misalign = ((size == F3_H[1:0]) & off[0]) |
                   ((size == F3_W[1:0]) & (|off[1:0])) |
                   ((size == F3_D[1:0]) & (|off));
    end

    // Load side: bring the addressed bytes down to bit 0, then sign/zero-extend by access type
    always_comb begin
        sh      = rdata >> {ld_off, 3'b000};
        ld_data = (ld_funct3 == F3_B)  ? {{(DATA_WIDTH-8){sh[7]}}, sh[7:0]} :
                  (ld_funct3 == F3_H)  ? {{(DATA_WIDTH-16){sh[15]}}, sh[15:0]} :
                  (ld_funct3 == F3_W)  ? {{(DATA_WIDTH-32){sh[31]}}, sh[31:0]} :
                  (ld_funct3 == F3_BU) ? {{(DATA_WIDTH-8){1'b0}}, sh[7:0]} :
                  (ld_funct3 == F3_HU) ? {{(DATA_WIDTH-16){1'b0}}, sh[15:0]} :
                  (ld_funct3 == F3_WU) ? {{(DATA_WIDTH-32){1'b0}}, sh[31:0]} : sh;
    end

endmodule

// File: rtl/cprv_mem_stage.sv
// cprv_mem_stage: RV64 memory stage - issues loads/stores on dmem, formats results, feeds writeback
module cprv_mem_stage
    import cprv_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_mem_i,
    output logic                  ready_mem_o,
    input  logic [DATA_WIDTH-1:0] alu_out_mem_i,
    input  logic [DATA_WIDTH-1:0] rs2_data_mem_i,
    input  logic [4:0]            rd_addr_mem_i,
    input  logic                  rd_en_mem_i,
    input  logic [6:0]            opcode_mem_i,
    input  logic [2:0]            funct3_mem_i,
    input  logic                  mem_w_en_mem_i,
    output logic                  dmem_req_o,
    output logic                  dmem_we_o,
    output logic [ADDR_WIDTH-1:0] dmem_addr_o,
    output logic [DATA_WIDTH-1:0] dmem_wdata_o,
    output logic [7:0]            dmem_wstrb_o,
    input  logic                  dmem_ack_i,
    input  logic [DATA_WIDTH-1:0] dmem_rdata_i,
    output logic                  valid_wb_o,
    input  logic                  ready_wb_i,
    output logic [4:0]            rd_addr_wb_o,
    output logic                  rd_en_wb_o,
    output logic [DATA_WIDTH-1:0] rd_data_wb_o,
    output logic                  misalign_wb_o
);

    mem_state_t            state;
    logic                  slot_free, is_load, is_store, is_mem, mis_raw, mis_op, take_mem;
    logic [7:0]            wstrb_n;
    logic [DATA_WIDTH-1:0] wdata_n, ld_data, res_data, hold_data, wb_data_n;
    logic [2:0]            funct3_q, off_q;
    logic [4:0]            rd_q;
    logic                  rd_en_q, we_q;

    cprv_lsu_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
        .size     (funct3_mem_i[1:0]),
        .off      (alu_out_mem_i[2:0]),
        .st_data  (rs2_data_mem_i),
        .wstrb    (wstrb_n),
        .wdata    (wdata_n),
        .misalign (mis_raw),
        .ld_funct3(funct3_q),
        .ld_off   (off_q),
        .rdata    (dmem_rdata_i),
        .ld_data  (ld_data)
    );

    // Decode the bundle and decide when an instruction enters the result register
    always_comb begin
        slot_free   = ~valid_wb_o | ready_wb_i;
        is_load     = opcode_mem_i == OPC_LOAD;
        is_store    = (opcode_mem_i == OPC_STORE) & mem_w_en_mem_i;
        is_mem      = is_load | is_store;
        mis_op      = is_mem & mis_raw;
        take_mem    = valid_mem_i & is_mem & ~mis_raw;
        res_data    = we_q ? '0 : ld_data;
        ready_mem_o = slot_free & (((state == IDLE) & valid_mem_i & ~take_mem) |
                                   ((state == REQ) & dmem_ack_i) |
                                   (state == HOLD));
        wb_data_n   = (state == IDLE) ? alu_out_mem_i :
                      (state == REQ)  ? res_data : hold_data;
    end

    // Access FSM: latch the request in IDLE, hold it stable through REQ, park unaccepted data in HOLD
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            dmem_req_o   <= 1'b0;
            dmem_we_o    <= 1'b0;
            dmem_addr_o  <= '0;
            dmem_wdata_o <= '0;
            dmem_wstrb_o <= '0;
            funct3_q     <= '0;
            off_q        <= '0;
            rd_q         <= '0;
            rd_en_q      <= 1'b0;
            we_q         <= 1'b0;
            hold_data    <= '0;
        end else begin
            case (state)
                IDLE: if (take_mem) begin
                    state        <= REQ;
                    dmem_req_o   <= 1'b1;
                    dmem_we_o    <= is_store;
                    dmem_addr_o  <= {alu_out_mem_i[ADDR_WIDTH-1:3], 3'b000};
                    dmem_wdata_o <= wdata_n;
                    dmem_wstrb_o <= is_store ? wstrb_n : 8'h00;
                    funct3_q     <= funct3_mem_i;
                    off_q        <= alu_out_mem_i[2:0];
                    rd_q         <= rd_addr_mem_i;
                    rd_en_q      <= rd_en_mem_i & is_load;
                    we_q         <= is_store;
                end
                REQ: if (dmem_ack_i) begin
                    dmem_req_o <= 1'b0;
                    hold_data  <= res_data;
                    state      <= slot_free ? IDLE : HOLD;
                end
                HOLD: if (slot_free) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Result register: load on acceptance, otherwise hold until writeback takes it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_wb_o    <= 1'b0;
            rd_addr_wb_o  <= '0;
            rd_en_wb_o    <= 1'b0;
            rd_data_wb_o  <= '0;
            misalign_wb_o <= 1'b0;
        end else if (ready_mem_o) begin
            valid_wb_o    <= 1'b1;
            rd_addr_wb_o  <= (state == IDLE) ? rd_addr_mem_i : rd_q;
            rd_en_wb_o    <= (state == IDLE) ? (rd_en_mem_i & ~mis_op) : rd_en_q;
            rd_data_wb_o  <= wb_data_n;
            misalign_wb_o <= (state == IDLE) & mis_op;
        end else if (ready_wb_i) begin
            valid_wb_o <= 1'b0;
        end
    end

    a_hold_bundle: assert property (@(posedge clk) disable iff (!rst_n) (state != IDLE) |-> valid_mem_i);

endmodule

// File: tb/tb_cprv_mem_stage.sv
// tb_cprv_mem_stage: directed and randomized checks of the MEM stage against a byte-level reference model
module tb_cprv_mem_stage;

    typedef struct packed {
        logic [63:0] alu;
        logic [63:0] rs2;
        logic [63:0] rdata;
        logic [4:0]  rd;
        logic        rd_en;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic        wen;
    } op_t;

    typedef struct packed {
        logic        memop;
        logic        mis;
        logic        we;
        logic        en;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] data;
        logic [7:0]  wstrb;
    } exp_t;

    localparam logic [6:0] LD_OP = 7'b0000011;
    localparam logic [6:0] ST_OP = 7'b0100011;
    localparam logic [6:0] RR_OP = 7'b0110011;
    localparam logic [6:0] RI_OP = 7'b0010011;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_mem_i = 1'b0, ready_mem_o;
    logic [63:0] alu_out_mem_i = '0, rs2_data_mem_i = '0;
    logic [4:0]  rd_addr_mem_i = '0;
    logic        rd_en_mem_i = 1'b0;
    logic [6:0]  opcode_mem_i = '0;
    logic [2:0]  funct3_mem_i = '0;
    logic        mem_w_en_mem_i = 1'b0;
    logic        dmem_req_o, dmem_we_o;
    logic [63:0] dmem_addr_o, dmem_wdata_o;
    logic [7:0]  dmem_wstrb_o;
    logic        dmem_ack_i = 1'b0;
    logic [63:0] dmem_rdata_i = '0;
    logic        valid_wb_o, ready_wb_i = 1'b0;
    logic [4:0]  rd_addr_wb_o;
    logic        rd_en_wb_o;
    logic [63:0] rd_data_wb_o;
    logic        misalign_wb_o;

    always #5 clk = ~clk;

    cprv_mem_stage dut (
        .clk(clk), .rst_n(rst_n),
        .valid_mem_i(valid_mem_i), .ready_mem_o(ready_mem_o),
        .alu_out_mem_i(alu_out_mem_i), .rs2_data_mem_i(rs2_data_mem_i),
        .rd_addr_mem_i(rd_addr_mem_i), .rd_en_mem_i(rd_en_mem_i),
        .opcode_mem_i(opcode_mem_i), .funct3_mem_i(funct3_mem_i), .mem_w_en_mem_i(mem_w_en_mem_i),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
        .dmem_wdata_o(dmem_wdata_o), .dmem_wstrb_o(dmem_wstrb_o),
        .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i),
        .valid_wb_o(valid_wb_o), .ready_wb_i(ready_wb_i),
        .rd_addr_wb_o(rd_addr_wb_o), .rd_en_wb_o(rd_en_wb_o),
        .rd_data_wb_o(rd_data_wb_o), .misalign_wb_o(misalign_wb_o)
    );

    int n_chk = 0, n_fail = 0;

    int          o_pulses, o_acc, o_reqs;
    logic        o_stable, o_we, o_vwb, o_en, o_mis, o_prev_v;
    logic [63:0] o_addr, o_wdata, o_data, o_prev_data;
    logic [7:0]  o_wstrb;
    logic [4:0]  o_rd;

    function automatic op_t mkop(input logic [63:0] alu, input logic [63:0] rs2, input logic [4:0] rd,
                                 input logic rd_en, input logic [6:0] opc, input logic [2:0] f3,
                                 input logic wen, input logic [63:0] rdata);
        op_t o;
        o.alu = alu; o.rs2 = rs2; o.rd = rd; o.rd_en = rd_en;
        o.opc = opc; o.f3 = f3; o.wen = wen; o.rdata = rdata;
        return o;
    endfunction

    // Reference: accesses described as byte lists at an offset of an 8-byte word
    function automatic exp_t model(input op_t op);
        exp_t e;
        int off, n;
        bit ld, st;
        logic [63:0] v;
        ld = op.opc == LD_OP;
        st = (op.opc == ST_OP) && op.wen;
        off = int'(op.alu[2:0]);
        n = 1 << op.f3[1:0];
        e.mis = (ld || st) && (off % n != 0);
        e.memop = (ld || st) && !e.mis;
        e.we = st;
        e.addr = op.alu - 64'(off);
        e.wstrb = '0;
        e.wdata = '0;
        v = '0;
        for (int i = 0; i < 8; i++) if (i >= off) e.wdata[8*i +: 8] = op.rs2[8*(i-off) +: 8];
        if (!e.mis) for (int i = 0; i < n; i++) begin
            e.wstrb[off+i] = 1'b1;
            v[8*i +: 8] = op.rdata[8*(off+i) +: 8];
        end
        if (!op.f3[2] && n < 8 && v[8*n-1]) v = v | (~64'h0 << (8*n));
        e.data = !e.memop ? op.alu : (st ? 64'h0 : v);
        e.en = e.memop ? (ld && op.rd_en) : (!e.mis && op.rd_en);
        return e;
    endfunction

    // Present one bundle from a negedge until accepted; memory acks on its (ack_dly+1)-th request cycle,
    // writeback is ready from cycle wb_on onwards.
    task automatic run_op(input op_t op, input int ack_dly, input int wb_on);
        int c = 0;
        int reqs = 0;
        bit done = 0;
        o_pulses = 0; o_acc = -1; o_stable = 1'b1; o_prev_v = 1'b0; o_prev_data = '0;
        o_addr = '0; o_we = 1'b0; o_wdata = '0; o_wstrb = '0;
        while (!done && c < 60) begin
            valid_mem_i = 1'b1;
            alu_out_mem_i = op.alu; rs2_data_mem_i = op.rs2; rd_addr_mem_i = op.rd; rd_en_mem_i = op.rd_en;
            opcode_mem_i = op.opc; funct3_mem_i = op.f3; mem_w_en_mem_i = op.wen;
            ready_wb_i = (c >= wb_on);
            dmem_ack_i = dmem_req_o && (reqs == ack_dly);
            dmem_rdata_i = dmem_ack_i ? op.rdata : {$urandom, $urandom};
            #1;
            if (c == wb_on - 1) begin o_prev_v = valid_wb_o; o_prev_data = rd_data_wb_o; end
            if (dmem_req_o) begin
                if (reqs == 0) begin
                    o_addr = dmem_addr_o; o_we = dmem_we_o; o_wdata = dmem_wdata_o; o_wstrb = dmem_wstrb_o;
                end else if ({dmem_addr_o, dmem_we_o, dmem_wdata_o, dmem_wstrb_o} !== {o_addr, o_we, o_wdata, o_wstrb}) begin
                    o_stable = 1'b0;
                end
                reqs++;
            end
            if (ready_mem_o) begin o_pulses++; o_acc = c; done = 1; end
            @(negedge clk);
            c++;
        end
        o_reqs = reqs;
        valid_mem_i = 1'b0; ready_wb_i = 1'b0; dmem_ack_i = 1'b0;
        #1;
        o_pulses += int'(ready_mem_o);
        o_vwb = valid_wb_o; o_rd = rd_addr_wb_o; o_en = rd_en_wb_o; o_data = rd_data_wb_o; o_mis = misalign_wb_o;
    endtask

    task automatic test_reset();
        #2;
        n_chk++; if (valid_wb_o !== 1'b0) begin n_fail++; $display("FAIL rst_valid_wb got %b want 0", valid_wb_o); end
        n_chk++; if (dmem_req_o !== 1'b0) begin n_fail++; $display("FAIL rst_dmem_req got %b want 0", dmem_req_o); end
        n_chk++; if ({dmem_we_o, rd_en_wb_o, misalign_wb_o, ready_mem_o} !== 4'b0) begin n_fail++; $display("FAIL rst_flags got %b want 0000", {dmem_we_o, rd_en_wb_o, misalign_wb_o, ready_mem_o}); end
        n_chk++; if ({dmem_addr_o, dmem_wdata_o, dmem_wstrb_o, rd_data_wb_o, rd_addr_wb_o} !== '0) begin n_fail++; $display("FAIL rst_data got addr=%h wdata=%h wstrb=%h rd_data=%h rd=%0d want all 0", dmem_addr_o, dmem_wdata_o, dmem_wstrb_o, rd_data_wb_o, rd_addr_wb_o); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_alu();
        run_op(mkop(64'h1234, 64'h0, 5'd5, 1'b1, RR_OP, 3'b000, 1'b0, 64'h0), 0, 0);
        n_chk++; if (o_acc !== 0) begin n_fail++; $display("FAIL alu_accept_cycle got %0d want 0", o_acc); end
        n_chk++; if (o_pulses !== 1) begin n_fail++; $display("FAIL alu_ready_pulses got %0d want 1", o_pulses); end
        n_chk++; if (o_reqs !== 0) begin n_fail++; $display("FAIL alu_dmem_req got %0d cycles want 0", o_reqs); end
        n_chk++; if ({o_vwb, o_en, o_mis, o_rd} !== {1'b1, 1'b1, 1'b0, 5'd5}) begin n_fail++; $display("FAIL alu_wb_ctrl got v=%b en=%b mis=%b rd=%0d want v=1 en=1 mis=0 rd=5", o_vwb, o_en, o_mis, o_rd); end
        n_chk++; if (o_data !== 64'h1234) begin n_fail++; $display("FAIL alu_wb_data got %h want 1234", o_data); end
    endtask

    task automatic test_store();
        run_op(mkop(64'h1003, 64'hAB, 5'd7, 1'b1, ST_OP, 3'b000, 1'b1, 64'h0), 0, 0);
        n_chk++; if (o_acc !== 1) begin n_fail++; $display("FAIL sb_accept_cycle got %0d want 1", o_acc); end
        n_chk++; if (o_reqs !== 1) begin n_fail++; $display("FAIL sb_req_cycles got %0d want 1", o_reqs); end
        n_chk++; if ({o_addr, o_we} !== {64'h1000, 1'b1}) begin n_fail++; $display("FAIL sb_addr got %h we=%b want 1000 we=1", o_addr, o_we); end
        n_chk++; if (o_wstrb !== 8'h08) begin n_fail++; $display("FAIL sb_wstrb got %h want 08", o_wstrb); end
        n_chk++; if (o_wdata !== 64'hAB00_0000) begin n_fail++; $display("FAIL sb_wdata got %h want ab000000", o_wdata); end
        n_chk++; if ({o_vwb, o_en, o_data} !== {1'b1, 1'b0, 64'h0}) begin n_fail++; $display("FAIL sb_retire got v=%b en=%b data=%h want v=1 en=0 data=0", o_vwb, o_en, o_data); end
    endtask

    task automatic test_load();
        logic [2:0]  f3s [2] = '{3'b000, 3'b100};
        logic [63:0] want[2] = '{64'hFFFF_FFFF_FFFF_FF80, 64'h80};
        for (int k = 0; k < 2; k++) begin
            run_op(mkop(64'h2005, 64'h0, 5'd10, 1'b1, LD_OP, f3s[k], 1'b0, 64'h0000_8011_2233_4455), 0, 0);
            n_chk++; if ({o_addr, o_we, o_acc} !== {64'h2000, 1'b0, 32'sd1}) begin n_fail++; $display("FAIL lb_req_%0d got addr=%h we=%b acc=%0d want 2000 0 1", k, o_addr, o_we, o_acc); end
            n_chk++; if (o_data !== want[k]) begin n_fail++; $display("FAIL lb_data_%0d got %h want %h", k, o_data, want[k]); end
            n_chk++; if ({o_vwb, o_en, o_rd} !== {1'b1, 1'b1, 5'd10}) begin n_fail++; $display("FAIL lb_ctrl_%0d got v=%b en=%b rd=%0d want 1 1 10", k, o_vwb, o_en, o_rd); end
        end
    endtask

    task automatic test_hold();
        run_op(mkop(64'h77, 64'h0, 5'd3, 1'b1, RI_OP, 3'b000, 1'b0, 64'h0), 0, 0);
        run_op(mkop(64'h200C, 64'h0, 5'd12, 1'b1, LD_OP, 3'b010, 1'b0, 64'h8765_4321_1111_2222), 3, 6);
        n_chk++; if (o_reqs !== 4) begin n_fail++; $display("FAIL hold_req_cycles got %0d want 4", o_reqs); end
        n_chk++; if (o_acc !== 6) begin n_fail++; $display("FAIL hold_accept_cycle got %0d want 6", o_acc); end
        n_chk++; if (o_pulses !== 1) begin n_fail++; $display("FAIL hold_ready_pulses got %0d want 1", o_pulses); end
        n_chk++; if ({o_prev_v, o_prev_data} !== {1'b1, 64'h77}) begin n_fail++; $display("FAIL hold_prev_held got v=%b data=%h want 1 77", o_prev_v, o_prev_data); end
        n_chk++; if ({o_vwb, o_en, o_data} !== {1'b1, 1'b1, 64'hFFFF_FFFF_8765_4321}) begin n_fail++; $display("FAIL hold_retire got v=%b en=%b data=%h want 1 1 ffffffff87654321", o_vwb, o_en, o_data); end
    endtask

    task automatic test_misalign();
        run_op(mkop(64'h3004, 64'h0, 5'd9, 1'b1, LD_OP, 3'b011, 1'b0, 64'h0), 0, 0);
        n_chk++; if ({o_reqs, o_acc} !== {32'sd0, 32'sd0}) begin n_fail++; $display("FAIL mis_no_req got reqs=%0d acc=%0d want 0 0", o_reqs, o_acc); end
        n_chk++; if ({o_vwb, o_mis, o_en} !== 3'b110) begin n_fail++; $display("FAIL mis_retire got v=%b mis=%b en=%b want 1 1 0", o_vwb, o_mis, o_en); end
    endtask

    task automatic test_reset_mid();
        run_op(mkop(64'h55, 64'h0, 5'd1, 1'b1, RR_OP, 3'b000, 1'b0, 64'h0), 0, 0);
        valid_mem_i = 1'b1; alu_out_mem_i = 64'h4000; opcode_mem_i = LD_OP; funct3_mem_i = 3'b011;
        rd_addr_mem_i = 5'd2; rd_en_mem_i = 1'b1; mem_w_en_mem_i = 1'b0; ready_wb_i = 1'b0; dmem_ack_i = 1'b0;
        @(negedge clk);
        #1;
        n_chk++; if ({dmem_req_o, valid_wb_o} !== 2'b11) begin n_fail++; $display("FAIL rstmid_before got req=%b vwb=%b want 1 1", dmem_req_o, valid_wb_o); end
        #2 rst_n = 1'b0;
        #1;
        n_chk++; if ({dmem_req_o, valid_wb_o} !== 2'b00) begin n_fail++; $display("FAIL rstmid_after got req=%b vwb=%b want 0 0", dmem_req_o, valid_wb_o); end
        valid_mem_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 4; k++) begin
            run_op(mkop(64'(100 + k), 64'h0, 5'(20 + k), 1'b1, RR_OP, 3'(k), 1'b0, 64'h0), 0, 0);
            n_chk++; if ({o_acc, o_data, o_rd, o_vwb} !== {32'sd0, 64'(100 + k), 5'(20 + k), 1'b1}) begin n_fail++; $display("FAIL b2b_%0d got acc=%0d data=%0d rd=%0d v=%b want 0 %0d %0d 1", k, o_acc, o_data, o_rd, o_vwb, 100 + k, 20 + k); end
        end
    endtask

    task automatic test_random();
        logic [6:0] opcs[4] = '{LD_OP, ST_OP, RR_OP, RI_OP};
        for (int k = 0; k < 60; k++) begin
            op_t  op;
            exp_t e;
            int   ad, wo;
            op.opc = opcs[$urandom % 4];
            op.f3 = (op.opc == ST_OP) ? 3'($urandom % 4) : 3'($urandom % 8);
            op.wen = ($urandom % 4) != 0;
            op.alu = {$urandom, $urandom};
            op.rs2 = {$urandom, $urandom};
            op.rdata = {$urandom, $urandom};
            op.rd = 5'($urandom);
            op.rd_en = 1'($urandom);
            ad = $urandom % 4;
            wo = $urandom % 3;
            e = model(op);
            run_op(op, ad, wo);
            n_chk++; if (o_acc < 0 || o_pulses !== 1) begin n_fail++; $display("FAIL rnd_%0d_handshake got acc=%0d pulses=%0d want accepted once", k, o_acc, o_pulses); end
            n_chk++; if ({o_vwb, o_mis, o_en, o_rd} !== {1'b1, e.mis, e.en, op.rd}) begin n_fail++; $display("FAIL rnd_%0d_ctrl got v=%b mis=%b en=%b rd=%0d want 1 %b %b %0d", k, o_vwb, o_mis, o_en, o_rd, e.mis, e.en, op.rd); end
            if (!e.mis) begin
                n_chk++; if (o_data !== e.data) begin n_fail++; $display("FAIL rnd_%0d_data op=%b f3=%b addr=%h got %h want %h", k, op.opc, op.f3, op.alu, o_data, e.data); end
            end
            n_chk++; if (o_reqs !== (e.memop ? ad + 1 : 0)) begin n_fail++; $display("FAIL rnd_%0d_req_cycles got %0d want %0d", k, o_reqs, e.memop ? ad + 1 : 0); end
            if (e.memop) begin
                n_chk++; if ({o_addr, o_we, o_stable} !== {e.addr, e.we, 1'b1}) begin n_fail++; $display("FAIL rnd_%0d_req got addr=%h we=%b stable=%b want %h %b 1", k, o_addr, o_we, o_stable, e.addr, e.we); end
                if (e.we) begin
                    n_chk++; if ({o_wstrb, o_wdata} !== {e.wstrb, e.wdata}) begin n_fail++; $display("FAIL rnd_%0d_store got strb=%h wdata=%h want %h %h", k, o_wstrb, o_wdata, e.wstrb, e.wdata); end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_store();
        test_load();
        test_hold();
        test_misalign();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
